// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and data/index widths.
// The receive side imports the same package.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_IDX_W  = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1.
// It pulses tick at the terminal count and then wraps.
// clr holds the count at zero so that the first bit of a frame starts from a clean count.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Free-running bit timer, cleared while idle and wrapped at the end of every bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == TERM)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = !clr && (r_cnt == TERM);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer.
// It accepts a byte over valid/ready and serialises it on tx.
// Frame order: start bit, data bits LSB first, optional parity bit, then 1 or 2 stop bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   done,
    output logic [UART_IDX_W-1:0]  bit_idx
);

    localparam logic ODD_BIT   = (PARITY_ODD != 0);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    tx_state_e              r_state;
    logic                   r_tx;
    logic                   r_done;
    logic [UART_IDX_W-1:0]  r_bit_idx;
    logic [UART_DATA_W-1:0] r_shift;
    logic                   r_parity;
    logic                   r_stop_cnt;
    logic                   w_tick;
    logic                   w_clr;

    // The divider only runs during a frame.
    // Every state change happens on a tick, where the divider wraps to zero anyway.
    assign w_clr = (r_state == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // Frame sequencer. The line level is registered here so that tx is glitch-free.
    // The parity bit is captured at acceptance because the shift register is consumed as bits go out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_shift  <= tx_data;
                        r_parity <= (^tx_data) ^ ODD_BIT;
                        r_tx     <= 1'b0;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[UART_DATA_W-1:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign done     = r_done;
    assign bit_idx  = r_bit_idx;
    assign tx_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);

endmodule
